// File: rtl/aes128_block_unloader.sv
// Byte-streaming unloader for AES-128 result blocks: a shift register drains the
// current block over valid/ready while a one-block pending buffer holds the next.
module aes128_block_unloader #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned OUT_W     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic [DATA_W-1:0] blk_data,
  input  logic              blk_valid,
  output logic              blk_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned NBEAT = DATA_W / OUT_W;
  localparam int unsigned CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEAT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   pend_q, pend_d;
  logic                pend_full_q, pend_full_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;

  logic in_xfer;
  logic out_xfer;

  assign blk_ready = !pend_full_q;
  assign in_xfer   = blk_valid & blk_ready;
  assign out_xfer  = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;

    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          shift_d = blk_data;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_xfer && cnt_q == LAST_BEAT) begin
          // Reload without a bubble: pending block first, else a same-cycle input.
          if (pend_full_q) begin
            shift_d     = pend_q;
            cnt_d       = '0;
            pend_full_d = 1'b0;
          end else if (in_xfer) begin
            shift_d = blk_data;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (out_xfer) begin
            shift_d = MSB_FIRST ? (shift_q << OUT_W) : (shift_q >> OUT_W);
            cnt_d   = cnt_q + 1'b1;
          end
          if (in_xfer) begin
            pend_d      = blk_data;
            pend_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == SEND);
    out_last_d  = (state_d == SEND) && (cnt_d == LAST_BEAT);
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = MSB_FIRST ? shift_q[DATA_W-1 -: OUT_W] : shift_q[OUT_W-1:0];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == SEND) | pend_full_q;

endmodule

// File: tb/tb_aes128_block_unloader.sv
// Bench for aes128_block_unloader: MSB-first and LSB-first instances share stimulus
// and are checked every cycle against a block-queue reference model.
module tb_aes128_block_unloader;

  logic         CLK = 1'b0;
  logic         RSTB;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         out_ready;

  logic       blk_ready_m, out_valid_m, out_last_m, busy_m;
  logic [7:0] out_data_m;
  logic       blk_ready_l, out_valid_l, out_last_l, busy_l;
  logic [7:0] out_data_l;

  always #5 CLK = ~CLK;

  aes128_block_unloader #(.DATA_W(128), .OUT_W(8), .MSB_FIRST(1'b1)) dut_m (
    .CLK(CLK), .RSTB(RSTB), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready_m), .out_data(out_data_m), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_last(out_last_m), .busy(busy_m)
  );

  aes128_block_unloader #(.DATA_W(128), .OUT_W(8), .MSB_FIRST(1'b0)) dut_l (
    .CLK(CLK), .RSTB(RSTB), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready_l), .out_data(out_data_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_last(out_last_l), .busy(busy_l)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference: blocks held by the unloader (head is draining) and the head's beat index.
  logic [127:0] q[$];
  int           beat = 0;

  localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
  localparam logic [127:0] BLK_C = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] beat_byte(input logic [127:0] b, input int k, input bit msb);
    int sh;
    sh = msb ? 8 * (15 - k) : 8 * k;
    return 8'(b >> sh);
  endfunction

  task automatic model_update();
    bit outx, inx;
    outx = (q.size() > 0) && out_ready;
    inx  = blk_valid && (q.size() < 2);
    if (outx) begin
      beat++;
      if (beat == 16) begin
        void'(q.pop_front());
        beat = 0;
      end
    end
    if (inx) q.push_back(blk_data);
  endtask

  task automatic check_all();
    check("valid_m", out_valid_m, q.size() > 0);
    check("valid_l", out_valid_l, q.size() > 0);
    check("ready_m", blk_ready_m, q.size() < 2);
    check("ready_l", blk_ready_l, q.size() < 2);
    check("busy_m", busy_m, q.size() > 0);
    check("busy_l", busy_l, q.size() > 0);
    if (q.size() > 0) begin
      check("data_m", out_data_m, beat_byte(q[0], beat, 1'b1));
      check("data_l", out_data_l, beat_byte(q[0], beat, 1'b0));
      check("last_m", out_last_m, beat == 15);
      check("last_l", out_last_l, beat == 15);
    end else begin
      check("last_idle_m", out_last_m, 1'b0);
      check("last_idle_l", out_last_l, 1'b0);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    check_all();
    blk_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic push_block(input logic [127:0] b);
    blk_valid = 1'b1;
    blk_data  = b;
    cyc();
    blk_valid = 1'b0;
  endtask

  task automatic drain();
    blk_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) cyc();
  endtask

  task automatic wait_for(input string tag, input int b, input int sz);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (q.size() == sz && beat == b) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check(tag, found, 1'b1);
  endtask

  initial begin
    RSTB      = 1'b0;
    blk_valid = 1'b0;
    out_ready = 1'b0;
    blk_data  = '0;
    #12;
    check("rst_valid", out_valid_m, 1'b0);
    check("rst_ready", blk_ready_m, 1'b1);
    check("rst_busy", busy_m, 1'b0);
    check("rst_last", out_last_m, 1'b0);
    check("rst_data_m", out_data_m, 8'h00);
    check("rst_data_l", out_data_l, 8'h00);
    @(negedge CLK);
    RSTB = 1'b1;
    cyc();

    // Single block, continuous ready: first beat one cycle after the transfer.
    out_ready = 1'b1;
    push_block(BLK_A);
    check("first_beat_m", out_data_m, 8'h00);
    check("first_beat_l", out_data_l, 8'hFF);
    check("first_valid", out_valid_m, 1'b1);
    drain();
    check("idle_busy", busy_m, 1'b0);

    // Backpressure held at beat 3.
    push_block(BLK_A);
    wait_for("reach_beat3", 3, 1);
    out_ready = 1'b0;
    repeat (5) cyc();
    check("hold_data_m", out_data_m, 8'h33);
    check("hold_data_l", out_data_l, 8'hCC);
    out_ready = 1'b1;
    drain();

    // Double buffering: B at beat 2, then C held off until space frees.
    push_block(BLK_A);
    wait_for("reach_beat2", 2, 1);
    push_block(BLK_B);
    check("pend_ready", blk_ready_m, 1'b0);
    blk_valid = 1'b1;
    blk_data  = BLK_C;
    for (int i = 0; i < 60; i++) begin
      bit acc;
      acc = (q.size() < 2);
      blk_data = BLK_C;
      cyc();
      if (acc) break;
    end
    blk_valid = 1'b0;
    drain();

    // Bypass on the exact last-beat cycle.
    push_block(BLK_A);
    wait_for("reach_last", 15, 1);
    push_block(BLK_B);
    check("bypass_ready", blk_ready_m, 1'b1);
    check("bypass_beat0", out_data_m, 8'hA0);
    drain();

    // Async reset mid-cycle during beat 7 with a block pending.
    push_block(BLK_A);
    wait_for("rst_beat2", 2, 1);
    push_block(BLK_B);
    wait_for("rst_beat7", 7, 2);
    #2;
    RSTB = 1'b0;
    #1;
    check("arst_valid", out_valid_m, 1'b0);
    check("arst_busy", busy_m, 1'b0);
    check("arst_ready", blk_ready_m, 1'b1);
    check("arst_last", out_last_l, 1'b0);
    check("arst_data", out_data_m, 8'h00);
    q.delete();
    beat = 0;
    @(negedge CLK);
    RSTB = 1'b1;
    cyc();
    push_block(BLK_C);
    check("post_rst_beat0", out_data_m, 8'h0F);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      blk_valid = ($urandom_range(0, 99) < 45);
      out_ready = (i % 300 < 100) ? 1'b1 : ($urandom_range(0, 99) < 70);
      cyc();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes128_block_unloader.md
Name: aes128_block_unloader

Overview:
- Reader side of the AES-128 core's block interface: takes a completed 128-bit result block (ciphertext or plaintext) from the cipher datapath and streams it out as bytes over a valid/ready handshake.
- A one-block pending buffer lets the core hand over the next result while the current one is still draining.
- Sits between the aes128 core output register and the byte-wide host/IO port.

Parameters:
- DATA_W, 128, block width in bits; must be a multiple of OUT_W.
- OUT_W, 8, output beat width in bits.
- MSB_FIRST, 1, 1 = beat 0 is bits [DATA_W-1 -: OUT_W]; 0 = beat 0 is bits [OUT_W-1:0].
- Derived: NBEAT = DATA_W/OUT_W (16). The beat counter is clog2(NBEAT) bits wide.

Ports:
- CLK, in, 1, rising-edge clock.
- RSTB, in, 1, asynchronous active-low reset.
- blk_data, in, DATA_W, result block from the core.
- blk_valid, in, 1, blk_data is valid.
- blk_ready, out, 1, unloader accepts the block this cycle.
- out_data, out, OUT_W, current output beat.
- out_valid, out, 1, out_data is valid.
- out_ready, in, 1, downstream accepts the beat.
- out_last, out, 1, current beat is beat NBEAT-1 of its block.
- busy, out, 1, shift register or pending buffer holds data.

Behaviour:
- Reset, async on RSTB low:
  - state=IDLE, beat counter=0, shift/pending registers=0, pend_full=0.
  - Outputs: out_valid=0, out_last=0, out_data=0, blk_ready=1, busy=0.
  - Registers are cleared immediately, not at the next clock edge.
- Handshakes:
  - Input transfer when blk_valid & blk_ready.
  - Output transfer when out_valid & out_ready.
  - out_data, out_valid and out_last are registered and hold stable while out_valid=1 and out_ready=0.
- blk_ready = !pend_full. This is combinational from a register only; there is no path from blk_valid to blk_ready.
- State IDLE:
  - out_valid=0.
  - On an input transfer, load blk_data into the shift register, set counter=0, go to SEND.
  - First beat appears with out_valid=1 the cycle after the transfer, so input-to-first-beat latency is 1 cycle.
- State SEND:
  - out_valid=1; out_data is the current beat per MSB_FIRST.
  - On an output transfer with counter < NBEAT-1: shift by OUT_W and increment counter.
  - On an output transfer with counter = NBEAT-1 (out_last=1):
    - if pend_full: move pending into shift, counter=0, pend_full=0, stay in SEND. The next block's beat 0 follows with no bubble.
    - else if an input transfer happens in the same cycle: load blk_data directly into shift, counter=0, stay in SEND.
    - else go to IDLE.
  - An input transfer in SEND that is not the last-beat bypass case writes the pending buffer and sets pend_full=1.
- Simultaneous events:
  - Last-beat transfer and input transfer in the same cycle with pend_full=0: the bypass load above applies; pend_full stays 0.
  - Last-beat transfer with pend_full=1: blk_ready is 0, so no input is taken that cycle. blk_ready returns to 1 the next cycle.
- Throughput: back-to-back blocks stream at 1 beat/cycle with no gaps when out_ready is held high.
- busy = (state==SEND) | pend_full.
- Reset asserted mid-block: the partial block and pending block are discarded and outputs return to reset values. After release the unloader accepts a new block normally.
- blk_data is sampled only on the transfer cycle; later changes to it have no effect.

Test Plan:
- Single block 0x00112233445566778899AABBCCDDEEFF, MSB_FIRST=1, out_ready=1:
  - 16 beats 0x00,0x11,...,0xFF on consecutive cycles starting 1 cycle after the transfer.
  - out_last=1 only on 0xFF; then IDLE, busy=0.
- Same block with MSB_FIRST=0: beats run 0xFF,0xEE,...,0x00, with out_last on 0x00.
- Backpressure:
  - Hold out_ready=0 for 5 cycles at beat 3: out_data stays 0x33 with out_valid=1 throughout.
  - Releasing out_ready resumes at 0x33; no beat is dropped or duplicated.
- Double buffering:
  - Present block B at beat 2 of block A: blk_ready=1, accepted, pend_full=1, then blk_ready=0.
  - Block C is held off until after A's last beat.
  - B's beat 0 follows A's beat 15 on the next cycle.
- Bypass: blk_valid with block B on exactly A's last-beat cycle, pend_full=0. Required: B accepted that cycle, B's beat 0 on the next cycle, pend_full never set.
- Async reset: drop RSTB mid-cycle during beat 7 with a block pending. Required: out_valid=0, busy=0, blk_ready=1 immediately, before the next CLK edge; a new block afterwards streams correctly from beat 0.
